fv_rvc_qed_issue_sched: RTL and testbench
=========================================

Name: fv_rvc_qed_issue_sched

Overview:
- Formal-harness scheduler that feeds constrained RVC instructions into the core instruction-fetch interface as a two-phase, QED-style sequence.
- ORIG phase: issues N legal free-variable candidates and buffers each one.
- SEP phase: issues one C.NOP separator.
- DUP phase: replays the buffered instructions in order, tagged as duplicates, for downstream register remapping and consistency checks.
- Sits between the RVC instruction-constraint logic (legality flag) and the core IF port.

Parameters:
- DEPTH, 8, max original instructions buffered per sequence (power of 2, >=2).
- INSTR_W, 16, compressed instruction width.
- CNT_W, $clog2(DEPTH+1), width of count fields.

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset. One clock; reset is asynchronous and active-low.
- start  in  1  begin a sequence; sampled only in IDLE.
- num_instr  in  CNT_W  requested original count; values >DEPTH clamp to DEPTH.
- cand_instr  in  INSTR_W  free candidate instruction.
- cand_legal  in  1  candidate lies in an included class (OR of the constraint include_* flags).
- cand_ctrl  in  1  candidate is a jump or branch. Treated as not replayable.
- if_ready  in  1  core accepts if_instr this cycle.
- if_valid  out  1  instruction offered.
- if_instr  out  INSTR_W  offered instruction.
- if_is_dup  out  1  offered instruction belongs to the DUP phase.
- busy  out  1  state != IDLE.
- done  out  1  one-cycle pulse when the sequence completes.
- nop_count  out  8  C.NOPs substituted for illegal candidates in the current sequence; saturates at 255.

Behaviour:
- Reset (async assert, sync deassert use): state=IDLE; buffer write/read pointers=0; issue count=0.
- Outputs at reset: if_valid=0, if_instr=16'h0001, if_is_dup=0, busy=0, done=0, nop_count=0.
- Output register:
  - if_valid/if_instr/if_is_dup are registered.
  - A new value loads only when the slot is free (!if_valid | if_ready).
  - While if_valid & !if_ready, all three hold stable.
  - This is a formal assumption target, so the stability property must hold.
- States: IDLE, ORIG, SEP, DUP, DONE.
- IDLE:
  - start=1 latches target = min(num_instr, DEPTH) and clears pointers and nop_count.
  - target>0 goes to ORIG; target==0 goes to DONE.
  - First if_valid no earlier than the cycle after start.
- ORIG, on each free slot:
  - If cand_legal & !cand_ctrl: load cand_instr, write it to buf[wr_ptr], increment wr_ptr.
  - Otherwise: load C.NOP (16'h0001), do not buffer, increment nop_count.
  - Leave ORIG when wr_ptr reaches target and the last loaded instruction is loaded into the output register. Go to SEP.
  - Pointers do not wrap within a sequence.
- SEP:
  - Load exactly one C.NOP with if_is_dup=0 into the free slot, then go to DUP.
  - The separator is loaded only after the last ORIG instruction has been accepted.
- DUP, on each free slot:
  - Load buf[rd_ptr] with if_is_dup=1 and increment rd_ptr.
  - When rd_ptr==target and the final duplicate is accepted, go to DONE.
- DONE:
  - done=1 for exactly one cycle; if_valid=0; then IDLE.
  - busy deasserts in the IDLE cycle.
- start while busy: ignored, with no effect on count or state.
- Simultaneous if_ready and state transition: the accepted instruction completes and the next instruction of the new phase may load in the same cycle. No bubble is required, but bubbles are legal only in SEP/DONE transitions.
- Illegal-candidate starvation: the ORIG phase may issue unbounded C.NOPs. No timeout.
- Reset mid-sequence: everything returns to reset values immediately; buffered contents are discarded; no done pulse.
- if_ready stuck at 0: the state machine holds with the offered instruction stable.

Test Plan:
- num_instr=3, all legal, if_ready=1, candidates 0x4501/0x4585/0x8d09 -> issue 0x4501, 0x4585, 0x8d09 (dup=0), then 0x0001 (dup=0), then 0x4501, 0x4585, 0x8d09 (dup=1); done pulses once; busy spans the sequence.
- num_instr=2; 2nd candidate illegal, then a legal candidate follows -> a C.NOP is inserted between the two originals; nop_count=1; only the 2 legal instructions are replayed in DUP.
- Candidate with cand_ctrl=1 (C.J) -> replaced by 0x0001; not buffered and not replayed.
- num_instr=0 -> no if_valid; done pulses the cycle after start.
- num_instr=15 with DEPTH=8 -> exactly 8 originals and 8 duplicates.
- if_ready low 5 cycles mid-DUP, then start pulsed and rst_n asserted -> if_instr holds stable while stalled; start has no effect; reset clears if_valid=0 and busy=0 immediately, with no done pulse.

Source files
------------

// File: rtl/fv_rvc_qed_issue_sched.sv
// QED-style RVC issue scheduler: issues N original candidates, a C.NOP separator,
// then replays the buffered originals tagged as duplicates on the core IF port.
module fv_rvc_qed_issue_sched #(
  parameter int unsigned DEPTH   = 8,
  parameter int unsigned INSTR_W = 16,
  parameter int unsigned CNT_W   = $clog2(DEPTH + 1)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [CNT_W-1:0]   num_instr,
  input  logic [INSTR_W-1:0] cand_instr,
  input  logic               cand_legal,
  input  logic               cand_ctrl,
  input  logic               if_ready,
  output logic               if_valid,
  output logic [INSTR_W-1:0] if_instr,
  output logic               if_is_dup,
  output logic               busy,
  output logic               done,
  output logic [7:0]         nop_count
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam logic [INSTR_W-1:0] C_NOP   = INSTR_W'(16'h0001);
  localparam logic [CNT_W-1:0]   DEPTH_C = CNT_W'(DEPTH);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_ORIG = 3'd1;
  localparam logic [2:0] S_SEP  = 3'd2;
  localparam logic [2:0] S_DUP  = 3'd3;
  localparam logic [2:0] S_DONE = 3'd4;

  logic [2:0]         state_q, state_d;
  logic [CNT_W-1:0]   target_q, target_d;
  logic [CNT_W-1:0]   wr_q, wr_d;
  logic [CNT_W-1:0]   rd_q, rd_d;
  logic [7:0]         nop_d;
  logic               valid_d, dup_d, busy_d, done_d;
  logic [INSTR_W-1:0] instr_d;
  logic               mem_we_c;
  logic               slot_free_c;
  logic [INSTR_W-1:0] mem_q [DEPTH];

  // Original-instruction replay buffer; contents are don't-care after reset.
  always_ff @(posedge clk) begin
    if (mem_we_c) mem_q[wr_q[PTR_W-1:0]] <= cand_instr;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      target_q  <= '0;
      wr_q      <= '0;
      rd_q      <= '0;
      nop_count <= 8'd0;
      if_valid  <= 1'b0;
      if_instr  <= C_NOP;
      if_is_dup <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      state_q   <= state_d;
      target_q  <= target_d;
      wr_q      <= wr_d;
      rd_q      <= rd_d;
      nop_count <= nop_d;
      if_valid  <= valid_d;
      if_instr  <= instr_d;
      if_is_dup <= dup_d;
      busy      <= busy_d;
      done      <= done_d;
    end
  end

  // Next-state and output-register load logic; the output slot only reloads when free.
  always_comb begin
    state_d     = state_q;
    target_d    = target_q;
    wr_d        = wr_q;
    rd_d        = rd_q;
    nop_d       = nop_count;
    valid_d     = if_valid;
    instr_d     = if_instr;
    dup_d       = if_is_dup;
    mem_we_c    = 1'b0;
    slot_free_c = !if_valid || if_ready;

    case (state_q)
      S_IDLE: begin
        if (slot_free_c) valid_d = 1'b0;
        if (start) begin
          target_d = (num_instr > DEPTH_C) ? DEPTH_C : num_instr;
          wr_d     = '0;
          rd_d     = '0;
          nop_d    = 8'd0;
          state_d  = (target_d == '0) ? S_DONE : S_ORIG;
        end
      end
      S_ORIG: begin
        if (slot_free_c) begin
          valid_d = 1'b1;
          dup_d   = 1'b0;
          if (cand_legal && !cand_ctrl) begin
            instr_d  = cand_instr;
            mem_we_c = 1'b1;
            wr_d     = wr_q + CNT_W'(1);
            if (wr_d == target_q) state_d = S_SEP;
          end else begin
            instr_d = C_NOP;
            if (nop_count != 8'hff) nop_d = nop_count + 8'd1;
          end
        end
      end
      S_SEP: begin
        if (slot_free_c) begin
          valid_d = 1'b1;
          instr_d = C_NOP;
          dup_d   = 1'b0;
          state_d = S_DUP;
        end
      end
      S_DUP: begin
        if (slot_free_c) begin
          if (rd_q == target_q) begin
            valid_d = 1'b0;
            instr_d = C_NOP;
            dup_d   = 1'b0;
            state_d = S_DONE;
          end else begin
            valid_d = 1'b1;
            instr_d = mem_q[rd_q[PTR_W-1:0]];
            dup_d   = 1'b1;
            rd_d    = rd_q + CNT_W'(1);
          end
        end
      end
      S_DONE: begin
        valid_d = 1'b0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    busy_d = (state_d != S_IDLE);
    done_d = (state_d == S_DONE);
  end

endmodule

// File: tb/tb_fv_rvc_qed_issue_sched.sv
// Self-checking bench for fv_rvc_qed_issue_sched: directed QED sequences plus
// randomized runs checked against a transaction-level model of the issue stream.
module tb_fv_rvc_qed_issue_sched;

  localparam int unsigned CNT_W = 4;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              start;
  logic [CNT_W-1:0]  num_instr;
  logic [15:0]       cand_instr;
  logic              cand_legal;
  logic              cand_ctrl;
  logic              if_ready;
  logic              if_valid;
  logic [15:0]       if_instr;
  logic              if_is_dup;
  logic              busy;
  logic              done;
  logic [7:0]        nop_count;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [15:0] instr;
    logic        dup;
    logic [15:0] src;
    logic        src_ok;
  } acc_t;

  acc_t        acc_q[$];
  int          done_cnt, done_cyc, stall_viol, busy_low;
  bit          timed_out;
  logic        post_busy, post_done;
  logic [7:0]  post_nop;

  int          dir_n;
  logic [15:0] dir_instr [16];
  logic        dir_legal [16];
  logic        dir_ctrl  [16];

  fv_rvc_qed_issue_sched dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .num_instr  (num_instr),
    .cand_instr (cand_instr),
    .cand_legal (cand_legal),
    .cand_ctrl  (cand_ctrl),
    .if_ready   (if_ready),
    .if_valid   (if_valid),
    .if_instr   (if_instr),
    .if_is_dup  (if_is_dup),
    .busy       (busy),
    .done       (done),
    .nop_count  (nop_count)
  );

  always #5 clk = ~clk;

  task automatic set_dir(input int idx, input logic [15:0] ins, input logic lg, input logic ct);
    dir_instr[idx] = ins;
    dir_legal[idx] = lg;
    dir_ctrl[idx]  = ct;
    if (idx + 1 > dir_n) dir_n = idx + 1;
  endtask

  // Candidate k is the one the DUT samples on the edge after the k-th negedge.
  task automatic drive(input int k, input bit directed, input int unsigned rdy_pct,
                       input int unsigned bad_pct);
    if (directed) begin
      if (k >= 1 && k - 1 < dir_n) begin
        cand_instr = dir_instr[k-1];
        cand_legal = dir_legal[k-1];
        cand_ctrl  = dir_ctrl[k-1];
      end else begin
        cand_instr = 16'h2222;
        cand_legal = 1'b0;
        cand_ctrl  = 1'b0;
      end
    end else begin
      cand_instr = 16'($urandom);
      cand_legal = ($urandom_range(99) >= bad_pct);
      cand_ctrl  = ($urandom_range(99) < 32'd10);
    end
    if_ready = ($urandom_range(99) < rdy_pct);
  endtask

  // Runs one sequence and records every accepted transfer with the candidate it was loaded from.
  task automatic run_seq(input int unsigned num, input bit directed, input int unsigned rdy_pct,
                         input int unsigned bad_pct);
    logic pf, pok, stall, s_dup, src_ok;
    logic [15:0] pc, s_instr, src;
    acc_q.delete();
    done_cnt = 0; done_cyc = -1; stall_viol = 0; busy_low = 0; timed_out = 1'b1;
    src = 16'h0; src_ok = 1'b0;
    start = 1'b1;
    num_instr = CNT_W'(num);
    drive(0, directed, rdy_pct, bad_pct);
    pf = !if_valid || if_ready; pc = cand_instr; pok = cand_legal && !cand_ctrl;
    stall = if_valid && !if_ready; s_instr = if_instr; s_dup = if_is_dup;
    for (int k = 1; k < 3000; k++) begin
      @(negedge clk);
      start = 1'b0;
      if (stall && (if_valid !== 1'b1 || if_instr !== s_instr || if_is_dup !== s_dup)) stall_viol++;
      if (busy !== 1'b1) busy_low++;
      if (done === 1'b1) begin done_cnt++; done_cyc = k; end
      if (pf) begin src = pc; src_ok = pok; end
      drive(k, directed, rdy_pct, bad_pct);
      if (if_valid && if_ready) acc_q.push_back('{if_instr, if_is_dup, src, src_ok});
      pf = !if_valid || if_ready; pc = cand_instr; pok = cand_legal && !cand_ctrl;
      stall = if_valid && !if_ready; s_instr = if_instr; s_dup = if_is_dup;
      if (done === 1'b1) begin timed_out = 1'b0; break; end
    end
    @(negedge clk);
    post_busy = busy; post_done = done; post_nop = nop_count;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0; num_instr = '0; cand_instr = 16'h0; cand_legal = 1'b0;
    cand_ctrl = 1'b0; if_ready = 1'b0;
    repeat (2) @(negedge clk);
    checks++; if (if_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", if_valid); end
    checks++; if (if_instr !== 16'h0001) begin errors++; $display("FAIL reset_instr: got %h want 0001", if_instr); end
    checks++; if (if_is_dup !== 1'b0) begin errors++; $display("FAIL reset_dup: got %b want 0", if_is_dup); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b want 0", done); end
    checks++; if (nop_count !== 8'd0) begin errors++; $display("FAIL reset_nop: got %0d want 0", nop_count); end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_basic();
    logic [15:0] ei [7] = '{16'h4501, 16'h4585, 16'h8d09, 16'h0001, 16'h4501, 16'h4585, 16'h8d09};
    logic        ed [7] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
    dir_n = 0;
    set_dir(0, 16'h4501, 1'b1, 1'b0);
    set_dir(1, 16'h4585, 1'b1, 1'b0);
    set_dir(2, 16'h8d09, 1'b1, 1'b0);
    run_seq(3, 1'b1, 100, 0);
    checks++; if (acc_q.size() != 7) begin errors++; $display("FAIL basic_len: got %0d want 7", acc_q.size()); end
    for (int i = 0; i < 7 && i < acc_q.size(); i++) begin
      checks++;
      if (acc_q[i].instr !== ei[i] || acc_q[i].dup !== ed[i]) begin
        errors++; $display("FAIL basic_item%0d: got %h/%b want %h/%b", i, acc_q[i].instr, acc_q[i].dup, ei[i], ed[i]);
      end
    end
    checks++; if (done_cnt != 1 || timed_out) begin errors++; $display("FAIL basic_done: got %0d pulses timeout=%0d want 1", done_cnt, timed_out); end
    checks++; if (busy_low != 0) begin errors++; $display("FAIL basic_busy: got %0d idle cycles want 0", busy_low); end
    checks++; if (post_busy !== 1'b0 || post_done !== 1'b0) begin errors++; $display("FAIL basic_end: got busy=%b done=%b want 0/0", post_busy, post_done); end
  endtask

  task automatic test_illegal_insert();
    logic [15:0] ei [6] = '{16'h4501, 16'h0001, 16'h4585, 16'h0001, 16'h4501, 16'h4585};
    logic        ed [6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    dir_n = 0;
    set_dir(0, 16'h4501, 1'b1, 1'b0);
    set_dir(1, 16'h1234, 1'b0, 1'b0);
    set_dir(2, 16'h4585, 1'b1, 1'b0);
    run_seq(2, 1'b1, 100, 0);
    checks++; if (acc_q.size() != 6) begin errors++; $display("FAIL illegal_len: got %0d want 6", acc_q.size()); end
    for (int i = 0; i < 6 && i < acc_q.size(); i++) begin
      checks++;
      if (acc_q[i].instr !== ei[i] || acc_q[i].dup !== ed[i]) begin
        errors++; $display("FAIL illegal_item%0d: got %h/%b want %h/%b", i, acc_q[i].instr, acc_q[i].dup, ei[i], ed[i]);
      end
    end
    checks++; if (post_nop !== 8'd1) begin errors++; $display("FAIL illegal_nopcnt: got %0d want 1", post_nop); end
  endtask

  task automatic test_ctrl_replaced();
    logic [15:0] ei [4] = '{16'h0001, 16'h4501, 16'h0001, 16'h4501};
    logic        ed [4] = '{1'b0, 1'b0, 1'b0, 1'b1};
    dir_n = 0;
    set_dir(0, 16'ha001, 1'b1, 1'b1);
    set_dir(1, 16'h4501, 1'b1, 1'b0);
    run_seq(1, 1'b1, 100, 0);
    checks++; if (acc_q.size() != 4) begin errors++; $display("FAIL ctrl_len: got %0d want 4", acc_q.size()); end
    for (int i = 0; i < 4 && i < acc_q.size(); i++) begin
      checks++;
      if (acc_q[i].instr !== ei[i] || acc_q[i].dup !== ed[i]) begin
        errors++; $display("FAIL ctrl_item%0d: got %h/%b want %h/%b", i, acc_q[i].instr, acc_q[i].dup, ei[i], ed[i]);
      end
    end
    checks++; if (post_nop !== 8'd1) begin errors++; $display("FAIL ctrl_nopcnt: got %0d want 1", post_nop); end
  endtask

  task automatic test_zero_count();
    run_seq(0, 1'b1, 100, 0);
    checks++; if (acc_q.size() != 0) begin errors++; $display("FAIL zero_len: got %0d want 0", acc_q.size()); end
    checks++; if (done_cyc != 1 || done_cnt != 1) begin errors++; $display("FAIL zero_done: got cycle %0d count %0d want 1/1", done_cyc, done_cnt); end
    checks++; if (post_busy !== 1'b0 || post_done !== 1'b0) begin errors++; $display("FAIL zero_end: got busy=%b done=%b want 0/0", post_busy, post_done); end
  endtask

  task automatic test_clamp();
    int n_dup = 0, n_orig = 0;
    run_seq(15, 1'b0, 70, 0);
    foreach (acc_q[i]) begin
      if (acc_q[i].dup) n_dup++;
      else n_orig++;
    end
    checks++; if (n_dup != 8) begin errors++; $display("FAIL clamp_dups: got %0d want 8", n_dup); end
    checks++; if (n_orig != 9 + int'(post_nop)) begin errors++; $display("FAIL clamp_origs: got %0d want %0d", n_orig, 9 + int'(post_nop)); end
    checks++; if (done_cnt != 1 || timed_out) begin errors++; $display("FAIL clamp_done: got %0d timeout=%0d want 1", done_cnt, timed_out); end
  endtask

  // Model: each ORIG slot carries its sampled candidate if legal and non-control, else C.NOP;
  // ORIG ends after min(N,DEPTH) legal ones; then one C.NOP; then the legal ones replayed.
  task automatic test_random_sequences();
    for (int s = 0; s < 24; s++) begin
      int unsigned num = $urandom_range(12, 0);
      int unsigned rdy = $urandom_range(100, 30);
      int unsigned bad = $urandom_range(60, 0);
      int tgt, i, nlegal, nops;
      logic [15:0] rep[$];
      logic [15:0] exp_i[$];
      logic        exp_d[$];
      run_seq(num, 1'b0, rdy, bad);
      tgt = (num > 8) ? 8 : int'(num);
      i = 0; nlegal = 0; nops = 0;
      while (nlegal < tgt && i < acc_q.size()) begin
        if (acc_q[i].src_ok) begin
          exp_i.push_back(acc_q[i].src); exp_d.push_back(1'b0); rep.push_back(acc_q[i].src); nlegal++;
        end else begin
          exp_i.push_back(16'h0001); exp_d.push_back(1'b0); nops++;
        end
        i++;
      end
      if (tgt > 0) begin
        exp_i.push_back(16'h0001); exp_d.push_back(1'b0);
        foreach (rep[j]) begin exp_i.push_back(rep[j]); exp_d.push_back(1'b1); end
      end
      checks++; if (acc_q.size() != exp_i.size()) begin errors++; $display("FAIL rand%0d_len: got %0d want %0d", s, acc_q.size(), exp_i.size()); end
      for (int j = 0; j < exp_i.size() && j < acc_q.size(); j++) begin
        checks++;
        if (acc_q[j].instr !== exp_i[j] || acc_q[j].dup !== exp_d[j]) begin
          errors++; $display("FAIL rand%0d_item%0d: got %h/%b want %h/%b", s, j, acc_q[j].instr, acc_q[j].dup, exp_i[j], exp_d[j]);
        end
      end
      checks++; if (post_nop !== 8'(nops)) begin errors++; $display("FAIL rand%0d_nopcnt: got %0d want %0d", s, post_nop, nops); end
      checks++; if (done_cnt != 1 || timed_out) begin errors++; $display("FAIL rand%0d_done: got %0d timeout=%0d want 1", s, done_cnt, timed_out); end
      checks++; if (stall_viol != 0) begin errors++; $display("FAIL rand%0d_stable: got %0d violations want 0", s, stall_viol); end
      checks++; if (busy_low != 0) begin errors++; $display("FAIL rand%0d_busy: got %0d idle cycles want 0", s, busy_low); end
      checks++; if (post_busy !== 1'b0 || post_done !== 1'b0) begin errors++; $display("FAIL rand%0d_end: got busy=%b done=%b want 0/0", s, post_busy, post_done); end
    end
  endtask

  task automatic test_stall_start_reset();
    logic [15:0] held;
    bit found = 1'b0;
    start = 1'b1; num_instr = 4'd4; cand_legal = 1'b1; cand_ctrl = 1'b0;
    cand_instr = 16'h4c01; if_ready = 1'b1;
    for (int k = 0; k < 60 && !found; k++) begin
      @(negedge clk);
      start = 1'b0;
      cand_instr = 16'h4c01 + 16'(k);
      if (if_valid && if_is_dup) found = 1'b1;
    end
    checks++; if (!found) begin errors++; $display("FAIL stall_reach_dup: got no duplicate within 60 cycles want one"); end
    if_ready = 1'b0;
    held = if_instr;
    repeat (5) begin
      @(negedge clk);
      checks++;
      if (if_valid !== 1'b1 || if_instr !== held || if_is_dup !== 1'b1) begin
        errors++; $display("FAIL stall_hold: got %b/%h/%b want 1/%h/1", if_valid, if_instr, if_is_dup, held);
      end
    end
    start = 1'b1; num_instr = 4'd2;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    checks++;
    if (if_valid !== 1'b1 || if_instr !== held || busy !== 1'b1 || done !== 1'b0) begin
      errors++; $display("FAIL stall_start_ignored: got v=%b %h busy=%b done=%b want 1 %h 1 0", if_valid, if_instr, busy, done, held);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (if_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || nop_count !== 8'd0 || if_instr !== 16'h0001) begin
      errors++; $display("FAIL midreset: got v=%b busy=%b done=%b nop=%0d instr=%h want 0 0 0 0 0001", if_valid, busy, done, nop_count, if_instr);
    end
    repeat (3) begin
      @(negedge clk);
      checks++; if (done !== 1'b0 || if_valid !== 1'b0) begin errors++; $display("FAIL midreset_hold: got done=%b v=%b want 0/0", done, if_valid); end
    end
    rst_n = 1'b1;
    @(negedge clk);
    checks++; if (busy !== 1'b0 || done !== 1'b0) begin errors++; $display("FAIL postreset_idle: got busy=%b done=%b want 0/0", busy, done); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_illegal_insert();
    test_ctrl_replaced();
    test_zero_count();
    test_clamp();
    test_random_sequences();
    test_stall_start_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
